// File: rtl/axis_i2c_pkg.sv
// Shared AXIS/I2C constants plus the init-sequencer table entry format.
package axis_i2c_pkg;

    localparam int AXIS_DATA_WIDTH = 16;
    localparam int I2C_DATA_WIDTH  = 8;
    localparam int I2C_RW_BIT      = 0;

    localparam int SEQ_ENTRY_WIDTH = 18;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_DELAY = 2'd2,
        OP_END   = 2'd3
    } seq_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP,
        S_DELAY
    } seq_state_t;

    // Counter width wide enough for the largest delay, gap and watchdog load.
    function automatic int seq_cnt_w(int dly_bits, int gap, int tmo);
        int w;
        w = dly_bits;
        if ($clog2(gap + 1) > w) w = $clog2(gap + 1);
        if ($clog2(tmo + 1) > w) w = $clog2(tmo + 1);
        return w;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream command channel towards the I2C master.
interface axis_if;
    import axis_i2c_pkg::*;

    logic                       tvalid;
    logic                       tready;
    logic [AXIS_DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_i2c_seq_timer.sv
// Loadable down-counter with zero flag; shared by gap/delay countdowns and the watchdog.
module axis_i2c_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/axis_i2c_init_seq.sv
// Table-driven I2C bring-up sequencer feeding the AXIS I2C master.
// Optional watchdog on stalled transactions: define I2C_SEQ_TIMEOUT_EN.
module axis_i2c_init_seq
    import axis_i2c_pkg::*;
#(
    parameter int TBL_AW         = 6,
    parameter int GAP_CYCLES     = 16,
    parameter int DELAY_SHIFT    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic [TBL_AW-1:0]          tbl_addr_o,
    input  logic [SEQ_ENTRY_WIDTH-1:0] tbl_data_i,
    input  logic                       rvalid_i,
    input  logic [I2C_DATA_WIDTH-1:0]  i2c_rdata_i,
    output logic [I2C_DATA_WIDTH-1:0]  rd_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    axis_if.master                     m_axis
);

    localparam int CNT_W = seq_cnt_w(16 + DELAY_SHIFT, GAP_CYCLES, TIMEOUT_CYCLES);

    seq_state_t state, state_nx;
    seq_op_t    op, cur_op;
    logic [15:0] payload;

    logic [TBL_AW-1:0]          addr_q;
    logic                       tvalid_q;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q;
    logic [I2C_DATA_WIDTH-1:0]  rd_q;
    logic                       busy_q, done_q;

    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic addr_rst, addr_inc, beat_load, beat_drop;
    logic done_set, busy_set, busy_clr, rd_cap;
    logic wd_hit, handshake;

    assign op        = seq_op_t'(tbl_data_i[17:16]);
    assign payload   = tbl_data_i[15:0];
    assign handshake = tvalid_q && m_axis.tready;

    axis_i2c_seq_timer #(.W(CNT_W)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    logic err_q, err_set, err_clr;
    // The timer is loaded with the watchdog limit at decode, so zero here means expiry.
    assign wd_hit = tmr_zero &&
                    (state == S_SEND || state == S_WAIT_BUSY || state == S_WAIT_DONE);
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (start_i) state_nx = S_FETCH;
            S_FETCH:     state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_WRITE, OP_READ: state_nx = S_SEND;
                    OP_DELAY:          state_nx = S_DELAY;
                    default:           state_nx = S_IDLE;
                endcase
            end
            S_SEND:      if (handshake) state_nx = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!m_axis.tready) state_nx = S_WAIT_DONE;
            S_WAIT_DONE: if (m_axis.tready) state_nx = S_GAP;
            S_GAP,
            S_DELAY:     if (tmr_zero) state_nx = S_FETCH;
            default:     state_nx = S_IDLE;
        endcase
        if (wd_hit) state_nx = S_IDLE;
    end

    always_comb begin
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        addr_rst  = 1'b0;
        addr_inc  = 1'b0;
        beat_load = 1'b0;
        beat_drop = 1'b0;
        done_set  = 1'b0;
        busy_set  = 1'b0;
        busy_clr  = 1'b0;
        rd_cap    = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        err_set   = 1'b0;
        err_clr   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    addr_rst = 1'b1;
                    busy_set = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
                    err_clr  = 1'b1;
`endif
                end
            end
            S_DECODE: begin
                case (op)
                    OP_WRITE, OP_READ: begin
                        beat_load = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                    OP_DELAY: begin
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(payload) << DELAY_SHIFT;
                    end
                    default: begin
                        done_set = 1'b1;
                        busy_clr = 1'b1;
                    end
                endcase
            end
            S_SEND: begin
                tmr_en    = 1'b1;
                beat_drop = handshake;
            end
            S_WAIT_BUSY: begin
                tmr_en = 1'b1;
                rd_cap = (cur_op == OP_READ) && rvalid_i;
            end
            S_WAIT_DONE: begin
                tmr_en = 1'b1;
                rd_cap = (cur_op == OP_READ) && rvalid_i;
                if (m_axis.tready) begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GAP_CYCLES);
                end
            end
            S_GAP, S_DELAY: begin
                tmr_en   = 1'b1;
                addr_inc = tmr_zero;
            end
            default: ;
        endcase
        if (wd_hit) begin
            beat_drop = 1'b1;
            busy_clr  = 1'b1;
            tmr_load  = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            err_set   = 1'b1;
`endif
        end
    end

    // tdata is only ever reloaded at decode, so it stays stable for the whole transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            cur_op   <= OP_WRITE;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_set;
            if (addr_rst)      addr_q <= '0;
            else if (addr_inc) addr_q <= addr_q + TBL_AW'(1);
            if (beat_load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= AXIS_DATA_WIDTH'(payload);
                cur_op   <= op;
            end else if (beat_drop) begin
                tvalid_q <= 1'b0;
            end
            if (busy_set)      busy_q <= 1'b1;
            else if (busy_clr) busy_q <= 1'b0;
            if (rd_cap) rd_q <= i2c_rdata_i;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)        err_q <= 1'b0;
        else if (err_clr) err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign tbl_addr_o    = addr_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign rd_data_o     = rd_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_axis_i2c_init_seq.sv
// Directed bench for axis_i2c_init_seq: ROM + I2C master model, beat scoreboard.
module tb_axis_i2c_init_seq;
    import axis_i2c_pkg::*;

    localparam int TBL_AW = 6;
    localparam int GAP    = 16;
    localparam int DSH    = 4;
    localparam int TMO    = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [TBL_AW-1:0] tbl_addr;
    logic [SEQ_ENTRY_WIDTH-1:0] tbl_data;
    logic rvalid;
    logic [7:0] rd_byte = 8'h3C;
    logic [7:0] rd_data;
    logic busy, done, err;

    axis_if ifc();

    axis_i2c_init_seq #(
        .TBL_AW(TBL_AW), .GAP_CYCLES(GAP), .DELAY_SHIFT(DSH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
        .rvalid_i(rvalid), .i2c_rdata_i(rd_byte),
        .rd_data_o(rd_data), .busy_o(busy), .done_o(done), .err_o(err),
        .m_axis(ifc)
    );

    always #5 clk = ~clk;

    logic [SEQ_ENTRY_WIDTH-1:0] rom [0:63];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Master model: drops tready after acceptance, pulses rvalid, returns to idle 4 cycles later.
    int hold = 0;
    bit stall = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            ifc.tready <= 1'b1;
            hold       <= 0;
            rvalid     <= 1'b0;
        end else begin
            rvalid <= (hold == 2);
            if (ifc.tvalid && ifc.tready) begin
                ifc.tready <= 1'b0;
                hold       <= 4;
            end else if (hold == 1) begin
                if (!stall) begin
                    ifc.tready <= 1'b1;
                    hold       <= 0;
                end
            end else if (hold > 1) begin
                hold <= hold - 1;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int beats = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && ifc.tvalid && ifc.tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL beat_extra: observed tdata 0x%0h expected no beat", ifc.tdata);
            end else begin
                check("beat_tdata", {16'h0, ifc.tdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    int r_dones, r_ktv, r_hold_bad;
    logic r_busy1, r_busy_done, r_err1;

    task automatic clr_rom;
        for (int i = 0; i < 64; i++) rom[i] = {OP_END, 16'h0000};
    endtask

    // Pulses start, then observes max cycles; k counts negedges after the start cycle.
    task automatic run(input int max, input logic [15:0] hold_val, input bit chk_hold,
                       input int restart_k);
        r_dones = 0; r_ktv = -1; r_hold_bad = 0;
        r_busy1 = 1'bx; r_busy_done = 1'bx; r_err1 = 1'bx;
        start = 1'b1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            start = (k == restart_k);
            if (k == 1) begin
                r_busy1 = busy;
                r_err1  = err;
            end
            if (ifc.tvalid && r_ktv < 0) r_ktv = k;
            if (chk_hold && r_ktv >= 0 && ifc.tdata !== hold_val) r_hold_bad++;
            if (done) begin
                r_dones++;
                r_busy_done = busy;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int b0, k_err, dn;
        bit got;
        clr_rom();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   {31'h0, busy}, 32'h0);
        check("rst_done",   {31'h0, done}, 32'h0);
        check("rst_err",    {31'h0, err},  32'h0);
        check("rst_tvalid", {31'h0, ifc.tvalid}, 32'h0);
        check("rst_tdata",  {16'h0, ifc.tdata}, 32'h0);
        check("rst_addr",   {26'h0, tbl_addr}, 32'h0);
        check("rst_rdata",  {24'h0, rd_data}, 32'h0);

        // Single write; rvalid is pulsed by the model but must not be captured for a write.
        clr_rom();
        rom[0] = {OP_WRITE, 16'hA540};
        exp_q.push_back(16'hA540);
        b0 = beats;
        run(60, 16'hA540, 1'b1, 0);
        check("w_busy_k1",    {31'h0, r_busy1}, 32'h1);
        check("w_tvalid_k",   r_ktv, 3);
        check("w_beats",      beats - b0, 1);
        check("w_tdata_hold", r_hold_bad, 0);
        check("w_done_cnt",   r_dones, 1);
        check("w_busy_done",  {31'h0, r_busy_done}, 32'h0);
        check("w_no_capture", {24'h0, rd_data}, 32'h0);
        check("w_err",        {31'h0, err}, 32'h0);
        repeat (3) @(negedge clk);

        clr_rom();
        rom[0] = {OP_READ, 16'h0041};
        exp_q.push_back(16'h0041);
        run(60, 16'h0041, 1'b1, 0);
        check("r_rdata",    {24'h0, rd_data}, 32'h3C);
        check("r_done_cnt", r_dones, 1);
        repeat (3) @(negedge clk);

        // DELAY decodes at k=2; 49 delay cycles + fetch + decode put tvalid at k=54.
        clr_rom();
        rom[0] = {OP_DELAY, 16'd3};
        rom[1] = {OP_WRITE, 16'h0102};
        exp_q.push_back(16'h0102);
        run(120, 16'h0102, 1'b1, 0);
        check("d_tvalid_k", r_ktv, 54);
        check("d_done_cnt", r_dones, 1);
        check("d_rdata_kept", {24'h0, rd_data}, 32'h3C);
        repeat (3) @(negedge clk);

        clr_rom();
        rom[0] = {OP_WRITE, 16'h1111};
        rom[1] = {OP_WRITE, 16'h2222};
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        b0 = beats;
        run(120, 16'h0, 1'b0, 10);
        check("s_beats",    beats - b0, 2);
        check("s_done_cnt", r_dones, 1);
        check("s_idle",     {31'h0, busy}, 32'h0);
        repeat (3) @(negedge clk);

        // Reset while the second write sits in S_WAIT_DONE.
        clr_rom();
        rom[0] = {OP_WRITE, 16'h7777};
        rom[1] = {OP_WRITE, 16'h5555};
        exp_q.push_back(16'h7777);
        exp_q.push_back(16'h5555);
        b0 = beats;
        got = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (beats - b0 == 2) got = 1'b1;
        end
        check("x_reached", {31'h0, got}, 32'h1);
        @(negedge clk);
        check("x_pre_addr", {26'h0, tbl_addr}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("x_tvalid", {31'h0, ifc.tvalid}, 32'h0);
        check("x_tdata",  {16'h0, ifc.tdata}, 32'h0);
        check("x_busy",   {31'h0, busy}, 32'h0);
        check("x_addr",   {26'h0, tbl_addr}, 32'h0);
        repeat (3) @(negedge clk);

        // Master never returns to idle after accepting the beat.
        clr_rom();
        rom[0] = {OP_WRITE, 16'h00AA};
        exp_q.push_back(16'h00AA);
        stall = 1'b1;
        k_err = -1;
        dn = 0;
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (err && k_err < 0) k_err = k;
            if (done) dn++;
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        check("t_err_k",  k_err, 103);
        check("t_busy",   {31'h0, busy}, 32'h0);
        check("t_tvalid", {31'h0, ifc.tvalid}, 32'h0);
        check("t_no_done", dn, 0);
        stall = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(16'h00AA);
        run(60, 16'h0, 1'b0, 0);
        check("t_err_clr",  {31'h0, r_err1}, 32'h0);
        check("t_done_cnt", r_dones, 1);
`else
        check("t_err_never", k_err, -1);
        check("t_busy_held", {31'h0, busy}, 32'h1);
        check("t_no_done",   dn, 0);
        stall = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("t_done_after", dn, 1);
`endif
        check("q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_i2c_init_seq.md
# axis_i2c_init_seq

Command sequencer directly upstream of the AXI-Stream I2C master. On a start pulse it walks an external command table (synchronous ROM, one-cycle read latency), issues each write/read entry as one AXIS beat to the master, and holds each beat stable until the master returns to idle. It also executes timed delays between entries and captures read results. It brings up I2C peripherals (codecs, sensors) after reset without a CPU.

## Interface
Parameters:
- TBL_AW, 6: table address width; maximum 2**TBL_AW entries.
- GAP_CYCLES, 16: idle cycles inserted after every completed I2C transaction (≥1).
- DELAY_SHIFT, 4: an OP_DELAY payload is multiplied by 2**DELAY_SHIFT cycles.
- TIMEOUT_CYCLES, 65535: watchdog limit; used only when I2C_SEQ_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  system clock; every register is clocked on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse that starts the sequence; ignored unless the block is idle.
- tbl_addr_o  out  TBL_AW  table read address; registered.
- tbl_data_i  in  SEQ_ENTRY_WIDTH (18)  table entry: [17:16] opcode, [15:0] payload. Valid one cycle after tbl_addr_o changes.
- rvalid_i  in  1  read-data strobe from the master.
- i2c_rdata_i  in  I2C_DATA_WIDTH  read byte from the master.
- rd_data_o  out  I2C_DATA_WIDTH  last byte captured by an OP_READ entry; reset 0.
- busy_o  out  1  high from start acceptance until done; reset 0.
- done_o  out  1  one-cycle pulse when OP_END executes; reset 0.
- err_o  out  1  sticky watchdog error, cleared by start_i; reset 0; tied 0 without the macro.
- m_axis  axis_if.master: tvalid, tready, tdata[AXIS_DATA_WIDTH-1:0]. Reset: tvalid 0, tdata 0.

## Operation
- Opcodes: OP_WRITE=0, OP_READ=1, OP_DELAY=2, OP_END=3.
- Payload for OP_WRITE/OP_READ is driven onto tdata unchanged: [15:8] data byte, [7:0] address byte with R/W in bit I2C_RW_BIT. The table author sets the R/W bit; the sequencer uses the opcode only to decide whether to capture read data.
- FSM states and transitions:
  - S_IDLE: on start_i, set tbl_addr_o=0, busy_o=1, clear err_o, go to S_FETCH.
  - S_FETCH: wait one cycle for ROM latency, then go to S_DECODE.
  - S_DECODE:
    - WRITE/READ: load tdata, set tvalid=1, go to S_SEND.
    - DELAY: load the delay counter with payload<<DELAY_SHIFT, go to S_DELAY. A payload of 0 takes the S_DELAY exit on its first cycle.
    - END: pulse done_o, clear busy_o, go to S_IDLE.
  - S_SEND: on tvalid&&tready, drop tvalid the next cycle (tdata is held), go to S_WAIT_BUSY.
  - S_WAIT_BUSY: wait for tready=0 (master has left its idle state), then go to S_WAIT_DONE.
  - S_WAIT_DONE: wait for tready=1. For OP_READ, latch i2c_rdata_i into rd_data_o on any rvalid_i seen while in S_WAIT_BUSY or S_WAIT_DONE. Load the gap counter with GAP_CYCLES, go to S_GAP.
  - S_GAP / S_DELAY: count down to 0, then increment tbl_addr_o and go to S_FETCH.
- tdata stays stable from S_DECODE until the next S_DECODE, because the master samples its R/W bit throughout the transaction.
- Address wrap: after the last entry (all ones) the address wraps to 0. Tables must end with OP_END; a table without it loops forever.
- start_i while busy_o=1: ignored.
- rst_i mid-transaction: all state returns to reset values at once. The master is reset separately and is not tracked.

## Timing
- start_i at cycle 0: tbl_addr_o=0 at cycle 1; tvalid=1 no earlier than cycle 3.
- tvalid falls the cycle after the handshake cycle.
- Entry-to-entry overhead after the master returns to idle: GAP_CYCLES + 2 (fetch + decode).
- OP_DELAY with payload P occupies P·2**DELAY_SHIFT + 1 cycles in S_DELAY.
- done_o is asserted in the cycle after OP_END decodes.

## Configuration
- I2C_SEQ_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in S_SEND, S_WAIT_BUSY and S_WAIT_DONE.
  - At TIMEOUT_CYCLES it sets err_o, drops tvalid, clears busy_o and returns to S_IDLE. done_o is not pulsed.
- Macro undefined: no watchdog logic is built, err_o is constant 0, and the sequencer waits indefinitely.

## Structure
- Add to axis_i2c_pkg:
  - seq_op_t enum (OP_WRITE/OP_READ/OP_DELAY/OP_END).
  - SEQ_ENTRY_WIDTH = 18.
  - Existing constants reused: AXIS_DATA_WIDTH, I2C_DATA_WIDTH, I2C_RW_BIT.
- One sub-module, axis_i2c_seq_timer: a loadable down-counter with a zero flag. It is shared by the S_GAP/S_DELAY countdowns and by the watchdog.
- The table ROM sits outside this block.

## Test plan
- Table {WRITE 0xA5_40, END}, master model asserts tready 4 cycles after acceptance:
  - one beat with tdata=0xA540;
  - tdata held until done_o;
  - done_o pulses once;
  - busy_o falls with it.
- Table {READ 0x00_41, END}, model pulses rvalid_i with 0x3C: rd_data_o=0x3C and the beat tdata=0x0041.
- Table {DELAY 3, WRITE 0x0102, END} with DELAY_SHIFT=4: cycle count from S_DECODE of DELAY to tvalid=1 is 49 + 2.
- start_i pulsed again mid-sequence: ignored, no extra beats, single done_o.
- rst_i asserted during S_WAIT_DONE: next cycle tvalid=0, tdata=0, busy_o=0, tbl_addr_o=0.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, tready held 0 after acceptance: err_o=1 after 100 cycles, busy_o=0, no done_o. Without the macro, err_o stays 0.
